// File: rtl/mac_arb_pkg.sv
// rtl/mac_arb_pkg.sv - shared types and constants for the mac_arbiter slice
//
// Holds the arbiter state enum, default parameter values and the width of
// the read-latency counter (sized for the largest supported RD_LAT of 4).
package mac_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 1;

    // Counter must hold RD_LAT up to 4.
    localparam int CNT_W = $clog2(4) + 1;

endpackage

// File: rtl/mac_arb_rr_picker.sv
// rtl/mac_arb_rr_picker.sv - combinational winner selection for mac_arbiter
//
// Picks one requester out of the active vector.
// Build option: MAC_ARB_FIXED_PRIO_EN selects fixed priority (lowest active
// index wins, ptr ignored); otherwise round-robin starting at ptr.
//
// Ports:
//   active  in  N_REQ  requesters currently presenting a command
//   ptr     in  IDX_W  round-robin start index
//   grant   out N_REQ  one-hot winner (all zero when nothing is active)
//   win_idx out IDX_W  binary index of the winner
module mac_arb_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] active,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] win_idx
);

`ifdef MAC_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan from the top down so the lowest active index is written last.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (active[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                win_idx  = IDX_W'(k);
            end
        end
    end
`else
    // Scan offsets from the far end back to ptr so the first active
    // requester at or after ptr (modulo N_REQ) is written last.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (active[(int'(ptr) + k) % N_REQ]) begin
                grant                               = '0;
                grant[(int'(ptr) + k) % N_REQ]      = 1'b1;
                win_idx = IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end
`endif

endmodule

// File: rtl/mac_arbiter.sv
// rtl/mac_arbiter.sv - N-way Avalon-MM arbiter in front of the mac slave port
//
// One transfer in flight at a time; writes finish in the issue cycle, reads
// return after the fixed slave latency RD_LAT. All outputs are registered.
// Build option: MAC_ARB_FIXED_PRIO_EN (fixed priority, no round-robin pointer).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_cs/read/write      per-requester Avalon strobes (N_REQ each)
//   req_address/writedata  packed per-requester command, slot i at [i*W +: W]
//   req_waitrequest        low only for the winner during its issue cycle
//   req_readdata           shared read data, qualified by req_readdatavalid
//   req_readdatavalid      one-hot, one-cycle read return pulse
//   m_*                    master side toward the mac slave
module mac_arbiter
    import mac_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_cs,
    input  logic [N_REQ-1:0]           req_read,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [N_REQ*ADDR_W-1:0]    req_address,
    input  logic [N_REQ*DATA_W-1:0]    req_writedata,
    output logic [N_REQ-1:0]           req_waitrequest,
    output logic [DATA_W-1:0]          req_readdata,
    output logic [N_REQ-1:0]           req_readdatavalid,
    output logic                       m_chipselect,
    output logic                       m_read,
    output logic                       m_write,
    output logic [ADDR_W-1:0]          m_address,
    output logic [DATA_W-1:0]          m_writedata,
    input  logic [DATA_W-1:0]          m_readdata
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       state;
    logic [IDX_W-1:0] win;
    logic             cmd_read;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] active;
    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_sel;

    assign active = req_cs & (req_read | req_write);

`ifdef MAC_ARB_FIXED_PRIO_EN
    assign ptr_sel = '0;
`else
    logic [IDX_W-1:0] p;
    assign ptr_sel = p;
`endif

    mac_arb_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .active  (active),
        .ptr     (ptr_sel),
        .grant   (pick_grant),
        .win_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            win               <= '0;
            cmd_read          <= 1'b0;
            cnt               <= '0;
`ifndef MAC_ARB_FIXED_PRIO_EN
            p                 <= '0;
`endif
            req_waitrequest   <= '1;
            req_readdatavalid <= '0;
            req_readdata      <= '0;
            m_chipselect      <= 1'b0;
            m_read            <= 1'b0;
            m_write           <= 1'b0;
            m_address         <= '0;
            m_writedata       <= '0;
        end else begin
            // Strobes and handshakes are single-cycle unless set below.
            m_chipselect      <= 1'b0;
            m_read            <= 1'b0;
            m_write           <= 1'b0;
            req_waitrequest   <= '1;
            req_readdatavalid <= '0;

            case (state)
                ST_IDLE: begin
                    if (|active) begin
                        // Outputs for the ISSUE cycle are loaded here so the
                        // command appears on m_* straight from flops.
                        // Read wins when read and write are both set.
                        win             <= pick_idx;
                        cmd_read        <= req_read[pick_idx];
                        m_chipselect    <= 1'b1;
                        m_read          <= req_read[pick_idx];
                        m_write         <= ~req_read[pick_idx];
                        m_address       <= req_address[pick_idx*ADDR_W +: ADDR_W];
                        m_writedata     <= req_writedata[pick_idx*DATA_W +: DATA_W];
                        req_waitrequest <= ~pick_grant;
`ifndef MAC_ARB_FIXED_PRIO_EN
                        p <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif
                        state           <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (cmd_read) begin
                        cnt   <= CNT_W'(RD_LAT);
                        state <= ST_RDWAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RDWAIT: begin
                    // cnt==1 is the cycle the count reaches zero: slave data
                    // is valid now and is returned from flops next cycle.
                    if (cnt == CNT_W'(1)) begin
                        req_readdata           <= m_readdata;
                        req_readdatavalid[win] <= 1'b1;
                        state                  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
